// File: rtl/counter_updown_lim.sv
// counter_updown_lim: up/down counter with parallel load, count enable,
// programmable upper limit, and wrap or saturate behaviour at the bounds.
// It has a one-cycle terminal-count pulse and sticky overflow/underflow flags.
// All outputs are registered and update on the same edge as the count.
module counter_updown_lim #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up_down,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  // Boundary detection. The up boundary uses >= so a count left above a
  // lowered limit still counts as a boundary on the next up step.
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_up_bnd;
  logic             w_dn_bnd;
  logic [WIDTH-1:0] w_load_val;

  // Combinational boundary and load-clamp terms.
  always_comb begin
    w_at_top   = (r_count >= limit);
    w_at_zero  = (r_count == '0);
    w_up_bnd   = !load && en &&  up_down && w_at_top;
    w_dn_bnd   = !load && en && !up_down && w_at_zero;
    w_load_val = (data > limit) ? limit : data;
  end

  // Count register: rst > load > en. No clamp on down steps above the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else if (load) begin
      r_count <= w_load_val;
    end else if (en) begin
      if (up_down) begin
        if (!w_at_top)     r_count <= r_count + 1'b1;
        else if (sat_mode) r_count <= limit;
        else               r_count <= '0;
      end else begin
        if (!w_at_zero)    r_count <= r_count - 1'b1;
        else if (sat_mode) r_count <= '0;
        else               r_count <= limit;
      end
    end
  end

  // Terminal-count pulse: high for the cycle after every boundary step.
  always_ff @(posedge clk) begin
    if (rst) r_tc <= 1'b0;
    else     r_tc <= w_up_bnd || w_dn_bnd;
  end

  // Sticky flags: a boundary event in the same cycle as clr_flags wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_up_bnd)       r_ovf <= 1'b1;
      else if (clr_flags) r_ovf <= 1'b0;
      if (w_dn_bnd)       r_unf <= 1'b1;
      else if (clr_flags) r_unf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
